// File: rtl/arc_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// register-zero constant, statistics counter width and a saturating increment.
package arc_pkg;

    localparam int         CNT_W    = 16;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/EX/MEM hazard inputs and pipeline control outputs of hazard_ctrl.
// The master side drives the pipeline observations, the slave side is the controller.
interface hazard_ctrl_if;
    import arc_pkg::*;

    logic             i_con_id_valid;
    logic [4:0]       i_addr_id_rs;
    logic [4:0]       i_addr_id_rt;
    logic             i_con_id_uses_rt;
    logic             i_con_ex_memread;
    logic [4:0]       i_addr_ex_rt;
    logic             i_con_mem_branch_taken;
    logic             i_con_cnt_clr;
    logic             o_con_pc_hold;
    logic             o_con_ifid_hold;
    logic             o_con_idex_bubble;
    logic             o_con_flush;
    logic [CNT_W-1:0] o_data_stall_cnt;
    logic [CNT_W-1:0] o_data_flush_cnt;

    modport master (
        output i_con_id_valid, i_addr_id_rs, i_addr_id_rt, i_con_id_uses_rt,
               i_con_ex_memread, i_addr_ex_rt, i_con_mem_branch_taken, i_con_cnt_clr,
        input  o_con_pc_hold, o_con_ifid_hold, o_con_idex_bubble, o_con_flush,
               o_data_stall_cnt, o_data_flush_cnt
    );

    modport slave (
        input  i_con_id_valid, i_addr_id_rs, i_addr_id_rt, i_con_id_uses_rt,
               i_con_ex_memread, i_addr_ex_rt, i_con_mem_branch_taken, i_con_cnt_clr,
        output o_con_pc_hold, o_con_ifid_hold, o_con_idex_bubble, o_con_flush,
               o_data_stall_cnt, o_data_flush_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare: the decode instruction reads the register an
// in-flight load in EX is about to write. Register 0 never creates a dependency.
module load_use_detect
    import arc_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_i,
    output logic       hazard_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt_i == id_rs_i);
    assign rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);
    assign hazard_o = id_valid_i && ex_memread_i && (ex_rt_i != REG_ZERO)
                      && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// saturating statistics counters, with zero-latency control outputs.
module hazard_ctrl
    import arc_pkg::*;
#(
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    hazard_ctrl_if.slave  hz
);

    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_STALL = 2'(STALL);
    localparam logic [1:0] S_FLUSH = 2'(FLUSH);

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazard;
    logic             branch;
    logic             hold;
    logic             flush;

    load_use_detect u_detect (
        .id_valid_i   (hz.i_con_id_valid),
        .id_rs_i      (hz.i_addr_id_rs),
        .id_rt_i      (hz.i_addr_id_rt),
        .id_uses_rt_i (hz.i_con_id_uses_rt),
        .ex_memread_i (hz.i_con_ex_memread),
        .ex_rt_i      (hz.i_addr_ex_rt),
        .hazard_o     (hazard)
    );

    assign branch = hz.i_con_mem_branch_taken;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        hold    = 1'b0;
        flush   = 1'b0;
        // A taken branch wins in every state and (re)starts the flush countdown.
        if (branch) begin
            flush   = 1'b1;
            state_d = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
            cnt_d   = FLUSH_RELOAD;
        end else begin
            case (state_q)
                S_STALL: begin
                    hold  = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = S_RUN;
                end
                S_FLUSH: begin
                    flush = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = S_RUN;
                end
                default: begin
                    if (hazard) begin
                        hold = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_d = S_STALL;
                            cnt_d   = STALL_RELOAD;
                        end
                    end
                end
            endcase
        end
    end

    // Clear beats increment; counters stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.i_con_cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (hold)   stall_cnt_d = sat_inc(stall_cnt_q);
            if (branch) flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_rst) begin
            state_q     <= S_RUN;
            cnt_q       <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Reset masks the control outputs combinationally, independent of the inputs.
    assign hz.o_con_pc_hold     = hold  && !i_rst;
    assign hz.o_con_ifid_hold   = hold  && !i_rst;
    assign hz.o_con_idex_bubble = hold  && !i_rst;
    assign hz.o_con_flush       = flush && !i_rst;
    assign hz.o_data_stall_cnt  = stall_cnt_q;
    assign hz.o_data_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three parameterisations driven by directed
// vectors; a monitor compares every queued expectation against the DUT outputs.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       clr;
    } stim_t;

    typedef struct {
        int          d;
        logic        hold;
        logic        flush;
        logic [15:0] sc;
        logic [15:0] fc;
        string       nm;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    stim_t stim_a, stim_b, stim_c;
    exp_t  sb[$];
    event  sample_now;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if if_a ();
    hazard_ctrl_if if_b ();
    hazard_ctrl_if if_c ();

    hazard_ctrl #(.LOAD_STALL(1), .FLUSH_CYCLES(1)) dut_a (.i_clk(clk), .i_rst(rst), .hz(if_a));
    hazard_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(3)) dut_b (.i_clk(clk), .i_rst(rst), .hz(if_b));
    hazard_ctrl #(.LOAD_STALL(4), .FLUSH_CYCLES(1)) dut_c (.i_clk(clk), .i_rst(rst), .hz(if_c));

    assign {if_a.i_con_id_valid, if_a.i_addr_id_rs, if_a.i_addr_id_rt, if_a.i_con_id_uses_rt,
            if_a.i_con_ex_memread, if_a.i_addr_ex_rt, if_a.i_con_mem_branch_taken,
            if_a.i_con_cnt_clr} = stim_a;
    assign {if_b.i_con_id_valid, if_b.i_addr_id_rs, if_b.i_addr_id_rt, if_b.i_con_id_uses_rt,
            if_b.i_con_ex_memread, if_b.i_addr_ex_rt, if_b.i_con_mem_branch_taken,
            if_b.i_con_cnt_clr} = stim_b;
    assign {if_c.i_con_id_valid, if_c.i_addr_id_rs, if_c.i_addr_id_rt, if_c.i_con_id_uses_rt,
            if_c.i_con_ex_memread, if_c.i_addr_ex_rt, if_c.i_con_mem_branch_taken,
            if_c.i_con_cnt_clr} = stim_c;

    function automatic stim_t mk(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses_rt, input logic memread,
                                 input logic [4:0] ex_rt, input logic br, input logic clr);
        return '{valid, rs, rt, uses_rt, memread, ex_rt, br, clr};
    endfunction

    localparam stim_t IDLE     = '0;
    localparam stim_t HAZ      = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0};
    localparam stim_t HAZ_BR   = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0};
    localparam stim_t HAZ_CLR  = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1};
    localparam stim_t BR       = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0};
    localparam stim_t CLR      = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1};

    function automatic logic [35:0] outs(input int d);
        case (d)
            0: return {if_a.o_con_pc_hold, if_a.o_con_ifid_hold, if_a.o_con_idex_bubble,
                       if_a.o_con_flush, if_a.o_data_stall_cnt, if_a.o_data_flush_cnt};
            1: return {if_b.o_con_pc_hold, if_b.o_con_ifid_hold, if_b.o_con_idex_bubble,
                       if_b.o_con_flush, if_b.o_data_stall_cnt, if_b.o_data_flush_cnt};
            default: return {if_c.o_con_pc_hold, if_c.o_con_ifid_hold, if_c.o_con_idex_bubble,
                             if_c.o_con_flush, if_c.o_data_stall_cnt, if_c.o_data_flush_cnt};
        endcase
    endfunction

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (hold3,flush,stall_cnt,flush_cnt)", nm, act, exp);
        end
    endtask

    task automatic expect_out(input int d, input logic h, input logic f,
                              input logic [15:0] sc, input logic [15:0] fc, input string nm);
        exp_t e;
        e.d = d; e.hold = h; e.flush = f; e.sc = sc; e.fc = fc; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic apply(input int d, input stim_t s);
        stim_a = (d == 0) ? s : IDLE;
        stim_b = (d == 1) ? s : IDLE;
        stim_c = (d == 2) ? s : IDLE;
    endtask

    // One clock cycle of stimulus plus the response expected while it is applied.
    task automatic cyc(input int d, input stim_t s, input logic h, input logic f,
                       input logic [15:0] sc, input logic [15:0] fc, input string nm);
        @(posedge clk);
        #1;
        apply(d, s);
        expect_out(d, h, f, sc, fc, nm);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or sample_now);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.nm, outs(e.d), {e.hold, e.hold, e.hold, e.flush, e.sc, e.fc});
            end
        end
    end

    initial begin : stimulus
        // Reset forces all control outputs low even with a branch and hazard present.
        stim_a = HAZ_BR; stim_b = HAZ_BR; stim_c = HAZ_BR;
        rst = 1'b1;
        #2;
        expect_out(0, 1'b0, 1'b0, 16'd0, 16'd0, "a_reset");
        expect_out(1, 1'b0, 1'b0, 16'd0, 16'd0, "b_reset");
        expect_out(2, 1'b0, 1'b0, 16'd0, 16'd0, "c_reset");
        -> sample_now;
        #9;
        apply(0, IDLE);
        #1;
        rst = 1'b0;

        // dut_a: LOAD_STALL=1, FLUSH_CYCLES=1
        cyc(0, HAZ,                                        1, 0, 16'd0, 16'd0, "a_haz_rs");
        cyc(0, IDLE,                                       0, 0, 16'd1, 16'd0, "a_one_cycle");
        cyc(0, mk(1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 0, 0),  0, 0, 16'd1, 16'd0, "a_reg_zero");
        cyc(0, mk(1, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 0, 0),  0, 0, 16'd1, 16'd0, "a_rt_unused");
        cyc(0, mk(1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 0, 0),  1, 0, 16'd1, 16'd0, "a_rt_used");
        cyc(0, mk(0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 0, 0),  0, 0, 16'd2, 16'd0, "a_not_valid");
        cyc(0, mk(1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 0, 0),  0, 0, 16'd2, 16'd0, "a_not_load");
        cyc(0, HAZ_BR,                                     0, 1, 16'd2, 16'd0, "a_branch_prio");
        cyc(0, IDLE,                                       0, 0, 16'd2, 16'd1, "a_flush_one");
        cyc(0, HAZ_CLR,                                    1, 0, 16'd2, 16'd1, "a_clr_with_hold");
        cyc(0, IDLE,                                       0, 0, 16'd0, 16'd0, "a_clr_result");

        // Drive the stall counter up to 0xFFFE, then into saturation.
        @(posedge clk);
        #1;
        apply(0, HAZ);
        repeat (65533) @(posedge clk);
        cyc(0, HAZ,     1, 0, 16'hFFFE, 16'd0, "a_preload");
        cyc(0, HAZ,     1, 0, 16'hFFFF, 16'd0, "a_reach_max");
        cyc(0, HAZ,     1, 0, 16'hFFFF, 16'd0, "a_sat_1");
        cyc(0, IDLE,    0, 0, 16'hFFFF, 16'd0, "a_sat_2");
        cyc(0, HAZ_CLR, 1, 0, 16'hFFFF, 16'd0, "a_sat_clr");
        cyc(0, IDLE,    0, 0, 16'd0,    16'd0, "a_sat_clr_result");

        // dut_b: LOAD_STALL=3, FLUSH_CYCLES=3; re-branch in 2nd flush cycle.
        cyc(1, HAZ_BR, 0, 1, 16'd0, 16'd0, "b_flush_c0");
        cyc(1, HAZ_BR, 0, 1, 16'd0, 16'd1, "b_flush_c1_rebranch");
        cyc(1, HAZ,    0, 1, 16'd0, 16'd2, "b_flush_c2");
        cyc(1, HAZ,    0, 1, 16'd0, 16'd2, "b_flush_c3");
        cyc(1, CLR,    0, 0, 16'd0, 16'd2, "b_flush_done");
        // Hazard then branch in the 2nd stall cycle.
        cyc(1, HAZ,    1, 0, 16'd0, 16'd0, "b_stall_c0");
        cyc(1, HAZ_BR, 0, 1, 16'd1, 16'd0, "b_abort_stall");
        cyc(1, HAZ,    0, 1, 16'd1, 16'd1, "b_abort_flush2");
        cyc(1, HAZ,    0, 1, 16'd1, 16'd1, "b_abort_flush3");
        cyc(1, IDLE,   0, 0, 16'd1, 16'd1, "b_abort_done");
        // Full stall: hazard is not re-evaluated inside STALL.
        cyc(1, HAZ,    1, 0, 16'd1, 16'd1, "b_full_stall_c0");
        cyc(1, IDLE,   1, 0, 16'd2, 16'd1, "b_full_stall_c1");
        cyc(1, IDLE,   1, 0, 16'd3, 16'd1, "b_full_stall_c2");
        cyc(1, IDLE,   0, 0, 16'd4, 16'd1, "b_full_stall_end");

        // dut_c: LOAD_STALL=4; asynchronous reset in the middle of a stall.
        cyc(2, BR,   0, 1, 16'd0, 16'd0, "c_branch");
        cyc(2, HAZ,  1, 0, 16'd0, 16'd1, "c_stall_c0");
        cyc(2, IDLE, 1, 0, 16'd1, 16'd1, "c_stall_c1");
        cyc(2, IDLE, 1, 0, 16'd2, 16'd1, "c_stall_c2");
        #6;
        stim_c = HAZ_BR;
        rst = 1'b1;
        #1;
        expect_out(2, 1'b0, 1'b0, 16'd0, 16'd0, "c_async_rst");
        -> sample_now;
        @(posedge clk);
        #2;
        stim_c = IDLE;
        #1;
        rst = 1'b0;
        cyc(2, HAZ,  1, 0, 16'd0, 16'd0, "c_after_rst_run");
        cyc(2, IDLE, 1, 0, 16'd1, 16'd0, "c_after_rst_stall");
        cyc(2, IDLE, 1, 0, 16'd2, 16'd0, "c_after_rst_stall2");

        @(negedge clk);
        #1;
        check("scoreboard_drain", 36'(sb.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL, default 1, meaning: hold cycles per load-use hazard, legal range 1..7.
REQ-002 Parameter FLUSH_CYCLES, default 1, meaning: flush cycles per taken branch, legal range 1..7.
REQ-003 i_clk  in  1  single clock; all state updates on posedge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_con_id_valid  in  1  decode-stage instruction valid.
REQ-006 i_addr_id_rs  in  5  decode rs field, bits 25:21.
REQ-007 i_addr_id_rt  in  5  decode rt field, bits 20:16.
REQ-008 i_con_id_uses_rt  in  1  decode instruction reads rt.
REQ-009 i_con_ex_memread  in  1  EX-stage instruction is a load.
REQ-010 i_addr_ex_rt  in  5  EX-stage load destination.
REQ-011 i_con_mem_branch_taken  in  1  MEM-stage branch resolved taken.
REQ-012 i_con_cnt_clr  in  1  synchronous clear of both counters.
REQ-013 o_con_pc_hold  out  1  freeze PC.
REQ-014 o_con_ifid_hold  out  1  freeze IF/ID register.
REQ-015 o_con_idex_bubble  out  1  zero control fields entering ID/EX.
REQ-016 o_con_flush  out  1  squash IF/ID, ID/EX and EX/MEM contents.
REQ-017 o_data_stall_cnt  out  16  count of cycles with o_con_pc_hold high.
REQ-018 o_data_flush_cnt  out  16  count of taken-branch flush events.

Function
REQ-019 FSM SHALL have exactly three states: RUN, STALL and FLUSH.
REQ-020 Hazard SHALL be defined as: id_valid, and ex_memread, and ex_rt != 0, and (ex_rt == id_rs, or (id_uses_rt and ex_rt == id_rt)).
REQ-021 In RUN with branch_taken high: o_con_flush = 1 in the same cycle, flush_cnt += 1, and the next state is FLUSH if FLUSH_CYCLES > 1, else RUN.
REQ-022 In RUN with branch_taken low and hazard high: pc_hold, ifid_hold and idex_bubble = 1 in the same cycle, and the next state is STALL if LOAD_STALL > 1, else RUN.
REQ-023 STALL SHALL assert pc_hold, ifid_hold and idex_bubble for LOAD_STALL-1 cycles, then return to RUN; hazard is not re-evaluated inside STALL.
REQ-024 FLUSH SHALL assert o_con_flush for FLUSH_CYCLES-1 cycles, then return to RUN; hazard detection is suppressed and all hold/bubble outputs are 0.
REQ-025 Branch_taken SHALL have priority over hazard in every state: in STALL it aborts the stall the same cycle (flush = 1, hold/bubble = 0, flush_cnt += 1, enter FLUSH or RUN per REQ-021).
REQ-026 Branch_taken in FLUSH SHALL restart the flush countdown at FLUSH_CYCLES-1 and increment flush_cnt.
REQ-027 o_con_pc_hold and o_con_ifid_hold SHALL always be equal; o_con_idex_bubble SHALL equal o_con_pc_hold.
REQ-028 o_con_flush and o_con_pc_hold SHALL never both be 1.
REQ-029 Outputs SHALL be combinational from state, countdown and inputs; there is zero-cycle latency from input to control output.
REQ-030 Both counters SHALL saturate at 0xFFFF.
REQ-031 i_con_cnt_clr SHALL zero both counters at the next edge and take priority over any same-cycle increment.
REQ-032 The countdown register SHALL be 3 bits wide and SHALL be decremented only in STALL or FLUSH.

Reset
REQ-033 i_rst high SHALL immediately force: state RUN, countdown 0, both counters 0.
REQ-034 i_rst high SHALL force every control output to 0, regardless of other inputs.
REQ-035 Reset mid-STALL or mid-FLUSH SHALL abandon the sequence; the first cycle after deassertion evaluates inputs as in RUN.

Structure
REQ-036 Shared package arc_pkg SHALL hold the state enum (RUN, STALL, FLUSH), REG_ZERO = 5'd0, and the counter width of 16.
REQ-037 The hazard compare of REQ-020 SHALL be a combinational sub-module named load_use_detect; the FSM, countdown and counters live in hazard_ctrl.

Verification
REQ-038 LOAD_STALL=1, ex_memread=1, ex_rt=5, id_rs=5, id_valid=1 for one cycle -> hold/bubble high exactly 1 cycle, stall_cnt=1.
REQ-039 ex_rt=0 matching id_rs=0, or ex_rt=7 matching id_rt=7 with uses_rt=0 -> no hold, stall_cnt unchanged.
REQ-040 LOAD_STALL=3 with a hazard, then branch_taken in the 2nd stall cycle -> hold high 1 cycle, flush high from the 2nd cycle, flush_cnt=1, stall_cnt=1.
REQ-041 FLUSH_CYCLES=3 with branch_taken pulsed, then again in flush cycle 2 -> flush high 4 consecutive cycles, flush_cnt=2, hazard ignored throughout.
REQ-042 Preload stall_cnt to 0xFFFE, hold for 3 cycles -> counter reads 0xFFFF; cnt_clr asserted together with a hold -> counter reads 0.
REQ-043 i_rst asserted asynchronously mid-STALL with LOAD_STALL=4 -> outputs 0 immediately, counters 0; after release, state is RUN.
